// File: rtl/calc_sequencer.sv
// calc_sequencer: runs one command through reg-file reads, ALU execution and write-back,
// and shares the reg-file write port with user/keypad writes.
module calc_sequencer #(
  parameter int W         = 9,
  parameter int NREG_BITS = 3,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_opcode,
  input  logic [NREG_BITS-1:0] cmd_src1,
  input  logic [NREG_BITS-1:0] cmd_src2,
  input  logic [NREG_BITS-1:0] cmd_dest,
  output logic [NREG_BITS-1:0] reg_sel,
  output logic [2:0]           alu_opcode,
  output logic                 assign_op1,
  output logic                 assign_op2,
  output logic                 alu_en,
  input  logic                 alu_done,
  input  logic [W-1:0]         alu_result,
  input  logic                 alu_ovf,
  input  logic                 user_wr_req,
  input  logic [NREG_BITS-1:0] user_wr_num,
  input  logic [W-1:0]         user_wr_data,
  output logic                 user_wr_grant,
  output logic                 wr_en,
  output logic [NREG_BITS-1:0] wr_num,
  output logic [W-1:0]         wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic                 ovf_flag
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {S_IDLE, S_RD1, S_RD2, S_EXEC, S_WAIT, S_WB} state_t;
  state_t               r_state, w_next;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_op;
  logic [NREG_BITS-1:0] r_src1, r_src2, r_dest;
  logic [W-1:0]         r_res;
  logic                 r_ovf, r_ovf_flag;
  logic                 w_idle, w_rd1, w_rd2, w_exec, w_wait, w_wb, w_tmo;
  assign w_idle = r_state == S_IDLE;
  assign w_rd1  = r_state == S_RD1;
  assign w_rd2  = r_state == S_RD2;
  assign w_exec = r_state == S_EXEC;
  assign w_wait = r_state == S_WAIT;
  assign w_wb   = r_state == S_WB;
  // r_cnt counts WAIT cycles already spent; this cycle is the last one allowed
  assign w_tmo  = (r_cnt + CW'(1)) == CW'(TIMEOUT);
  always_comb begin
    w_next = S_IDLE;
    unique case (r_state)
      S_IDLE:  w_next = cmd_valid ? S_RD1 : S_IDLE;
      S_RD1:   w_next = S_RD2;
      S_RD2:   w_next = S_EXEC;
      S_EXEC:  w_next = S_WAIT;
      S_WAIT:  w_next = alu_done ? S_WB : w_tmo ? S_IDLE : S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_src1     <= '0;
      r_src2     <= '0;
      r_dest     <= '0;
      r_res      <= '0;
      r_ovf      <= 1'b0;
      r_ovf_flag <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_wait ? r_cnt + CW'(1) : '0;
      if (w_idle && cmd_valid) begin
        r_op   <= cmd_opcode;
        r_src1 <= cmd_src1;
        r_src2 <= cmd_src2;
        r_dest <= cmd_dest;
      end
      if (w_wait && alu_done) begin
        r_res <= alu_result;
        r_ovf <= alu_ovf;
      end
      if (w_wb) r_ovf_flag <= r_ovf;
    end
  end
  // every output is forced quiet while reset is held, even before the reset edge
  assign cmd_ready     = nrst && w_idle;
  assign busy          = nrst && !w_idle;
  assign assign_op1    = nrst && w_rd1;
  assign assign_op2    = nrst && w_rd2;
  assign alu_en        = nrst && w_exec;
  assign done          = nrst && w_wb;
  assign err_timeout   = nrst && w_wait && !alu_done && w_tmo;
  assign reg_sel       = !nrst ? '0 : w_rd1 ? r_src1 : w_rd2 ? r_src2 : '0;
  assign alu_opcode    = (nrst && !w_idle) ? r_op : '0;
  assign wr_en         = nrst && (w_wb || user_wr_req);
  assign wr_num        = !nrst ? '0 : w_wb ? r_dest : user_wr_num;
  assign wr_data       = !nrst ? '0 : w_wb ? r_res : user_wr_data;
  assign user_wr_grant = nrst && !w_wb && user_wr_req;
  assign ovf_flag      = r_ovf_flag;
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Command-level controller for the calculator datapath.
- Accepts one command (opcode, src1, src2, dest) and sequences it through the register file and ALU:
  - read src1 into ALU operand 1
  - read src2 into ALU operand 2
  - fire the ALU and wait for its result
  - write the result back to dest
- Also arbitrates the register-file write port between keypad/user writes and its own write-back.
- Sits between the key/opcode encoders and reg_file/alu.

Parameters:
- W, 9, datapath width (sign + 8 magnitude bits).
- NREG_BITS, 3, register index width (8 registers).
- TIMEOUT, 15, maximum WAIT cycles before the command is aborted.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- nrst  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_opcode  in  3  ALU opcode.
- cmd_src1  in  NREG_BITS  first source register.
- cmd_src2  in  NREG_BITS  second source register.
- cmd_dest  in  NREG_BITS  destination register.
- reg_sel  out  NREG_BITS  register-file read select.
- alu_opcode  out  3  opcode presented to ALU.
- assign_op1  out  1  ALU captures reg_val as operand 1.
- assign_op2  out  1  ALU captures reg_val as operand 2.
- alu_en  out  1  one-cycle ALU start.
- alu_done  in  1  ALU result valid strobe.
- alu_result  in  W  ALU result.
- alu_ovf  in  1  ALU overflow flag.
- user_wr_req  in  1  user/keypad register write request.
- user_wr_num  in  NREG_BITS  user write target register.
- user_wr_data  in  W  user write data.
- user_wr_grant  out  1  user write performed this cycle.
- wr_en  out  1  register-file write enable.
- wr_num  out  NREG_BITS  register-file write index.
- wr_data  out  W  register-file write data.
- busy  out  1  command in flight.
- done  out  1  one-cycle pulse: write-back performed.
- err_timeout  out  1  one-cycle pulse: command aborted.
- ovf_flag  out  1  overflow of last completed command (held).

Behaviour:

States and transitions:
- IDLE:
  - cmd_ready=1.
  - cmd_valid=1: latch opcode/src1/src2/dest, go to RD1.
- RD1 (1 cycle): reg_sel=src1, assign_op1=1; go to RD2.
- RD2 (1 cycle): reg_sel=src2, assign_op2=1; go to EXEC.
- EXEC (1 cycle): alu_en=1, alu_opcode=latched opcode; clear wait counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - alu_done=1: latch alu_result and alu_ovf, go to WB.
  - Otherwise, when the counter reaches TIMEOUT: err_timeout pulse, go to IDLE with no write. ovf_flag is unchanged.
  - alu_done in the same cycle as the counter limit: done wins.
- WB (1 cycle): wr_en=1, wr_num=dest, wr_data=latched result; done=1; ovf_flag<=latched ovf; go to IDLE.

Output rules:
- alu_opcode holds the latched opcode in all non-IDLE states.
- reg_sel=0 in IDLE, EXEC, WAIT and WB.
- busy=1 in every state except IDLE.
- Only one command is ever in flight; no queueing.

Latency:
- Command accepted on edge 0; RD1, RD2, EXEC follow on cycles 1-3.
- With alu_done in the first WAIT cycle (cycle 4), WB is cycle 5 and cmd_ready returns at cycle 6.
- Back-to-back commands: issue interval 6 cycles minimum.

Write-port arbitration (combinational mux):
- In WB the sequencer owns the port and user_wr_grant=0. The user must hold user_wr_req; it is granted the next cycle.
- In all other states: wr_en=user_wr_req, wr_num/wr_data pass through, user_wr_grant=user_wr_req.
- User writes to a source register before its RD cycle are visible to that read. No hazard blocking.

Widths:
- Data passes unmodified; no arithmetic in this block.
- src1==src2 and dest==src are legal.

Reset:
- nrst=0 at any edge: state=IDLE, wait counter=0, latched command/result=0, ovf_flag=0.
- Every control output (cmd_ready, busy, done, err_timeout, assign_op1/2, alu_en, wr_en, user_wr_grant) is 0 while nrst=0.
- reg_sel, alu_opcode, wr_num and wr_data are 0 while nrst=0.
- Reset mid-command aborts it with no write-back and no done/err pulse.

Test Plan:
1. Command ADD src1=2, src2=5, dest=7; alu_done with result 0x023 one cycle after alu_en:
   - assign_op1 at cycle 1 with reg_sel=2.
   - assign_op2 at cycle 2 with reg_sel=5.
   - alu_en at cycle 3.
   - WB at cycle 5: wr_en=1, wr_num=7, wr_data=0x023, done=1.
   - cmd_ready=1 at cycle 6.
2. alu_done never asserted: err_timeout pulses after 15 WAIT cycles; no wr_en; ovf_flag unchanged; cmd_ready then 1.
3. alu_done with alu_ovf=1, result 0x1FF: ovf_flag=1 after WB. A next command with ovf=0 clears it.
4. user_wr_req (num 3, data 0x011) held across WB of a command writing reg 7:
   - WB cycle: wr_num=7, user_wr_grant=0.
   - Next cycle: wr_num=3, wr_data=0x011, user_wr_grant=1.
5. nrst=0 during WAIT: next cycle all outputs 0, no write-back, no done. After release, a new command completes normally.
6. cmd_valid held high continuously with 3 distinct commands: each accepted only in IDLE; exactly 3 done pulses; results land in their correct dest registers.
